// File: rtl/image_refill_pkg.sv
// Shared types and constants for the ImageController pixel-FIFO refill scheduler.
package image_refill_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EVAL      = 3'd1,
    IRQ       = 3'd2,
    WAIT_DATA = 3'd3,
    DONE      = 3'd4
  } refill_state_t;

  localparam int unsigned STATUS_LEN_LSB = 64;
  localparam int unsigned STATUS_ADDR_W  = 39;

  // Burst length is the smaller of the beats still owed and the burst cap.
  function automatic logic [8:0] min_len(input logic [31:0] rem, input logic [31:0] max);
    logic [31:0] w_sel;
    w_sel = (rem < max) ? rem : max;
    return w_sel[8:0];
  endfunction

endpackage

// File: rtl/image_refill_scheduler.sv
// Interrupt-driven refill sequencer: requests bursts when the pixel FIFO drains,
// then counts host write beats and walks the frame address forward.
module image_refill_scheduler
  import image_refill_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4096,
  parameter int unsigned MAX_BURST     = 256,
  parameter int unsigned LOW_WATERMARK = 2048,
  parameter int unsigned BEAT_BYTES    = 16
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic                          cfg_enable,
  input  logic                          cfg_loop,
  input  logic [38:0]                   cfg_base_addr,
  input  logic [31:0]                   cfg_total_words,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          irq_ack,
  input  logic                          beat_valid,
  input  logic                          beat_last,
  output logic                          irq_signal,
  output logic [127:0]                  status_word,
  output logic [31:0]                   words_remaining,
  output logic                          frame_done,
  output logic                          busy,
  output logic                          err_sticky
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  refill_state_t r_state, w_next;
  logic [31:0]   r_rem;
  logic [38:0]   r_addr;
  logic [38:0]   r_req_addr;
  logic [8:0]    r_req_len;
  logic [8:0]    r_cnt;
  logic          r_err;

  logic [8:0]    w_len;
  logic [LW:0]   w_free;
  logic          w_req_ok;
  logic          w_start;
  logic          w_final;

  // Free space computed one bit wider; an over-range level reads as full.
  always_comb begin
    w_len  = min_len(r_rem, 32'(MAX_BURST));
    w_free = '0;
    if (32'(fifo_level) <= FIFO_DEPTH)
      w_free = (LW+1)'(FIFO_DEPTH) - {1'b0, fifo_level};
    w_req_ok = (32'(fifo_level) <= LOW_WATERMARK) && (32'(w_free) >= 32'(w_len));
    w_start  = cfg_enable && (cfg_total_words != '0);
    w_final  = (r_cnt == (r_req_len - 9'd1));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_start) w_next = EVAL;
      EVAL: begin
        if (!cfg_enable)        w_next = IDLE;
        else if (r_rem == '0)   w_next = DONE;
        else if (w_req_ok)      w_next = IRQ;
      end
      IRQ: begin
        if (irq_ack)            w_next = WAIT_DATA;
        else if (!cfg_enable)   w_next = IDLE;
      end
      WAIT_DATA: if (beat_valid && w_final) w_next = cfg_enable ? EVAL : IDLE;
      DONE: w_next = (cfg_loop && cfg_enable) ? EVAL : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      r_addr     <= '0;
      r_req_addr <= '0;
      r_req_len  <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (beat_valid && (r_state != WAIT_DATA))
        r_err <= 1'b1;
      case (r_state)
        IDLE: if (w_start) begin
          r_rem  <= cfg_total_words;
          r_addr <= cfg_base_addr;
          r_cnt  <= '0;
          r_err  <= 1'b0;
        end
        EVAL: if (w_next == IRQ) begin
          r_req_len  <= w_len;
          r_req_addr <= r_addr;
        end
        WAIT_DATA: if (beat_valid) begin
          if (w_final) begin
            r_rem  <= r_rem - 32'(r_req_len);
            r_addr <= r_addr + (39'(r_req_len) * 39'(BEAT_BYTES));
            r_cnt  <= '0;
            if (!beat_last) r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 9'd1;
            if (beat_last) r_err <= 1'b1;
          end
        end
        DONE: if (cfg_loop && cfg_enable) begin
          r_rem  <= cfg_total_words;
          r_addr <= cfg_base_addr;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    irq_signal      = (r_state == IRQ);
    frame_done      = (r_state == DONE);
    busy            = (r_state != IDLE);
    err_sticky      = r_err;
    words_remaining = r_rem;
    status_word     = '0;
    status_word[STATUS_LEN_LSB +: 64]  = 64'(r_req_len);
    status_word[STATUS_ADDR_W-1:0]     = r_req_addr;
  end

endmodule

// File: doc/image_refill_scheduler.md
Name: image_refill_scheduler

Overview:
- Interrupt-driven refill sequencer for the ImageController pixel FIFO; runs in the s_axi_aclk domain beside the ImageController AXI slave.
- Watches FIFO fill level and raises irq_signal with a status word giving the next burst's address and length.
- After the host acknowledges by reading the status register, it counts the host's 128-bit write beats into the FIFO, then advances through the frame.
- Supports one-shot and looping (AUTOSTART) operation.

Parameters:
FIFO_DEPTH, 4096, pixel FIFO depth in 128-bit words; power of two.
MAX_BURST, 256, maximum beats per requested burst; 1..256.
LOW_WATERMARK, 2048, a request is issued only when fifo_level <= this value.
BEAT_BYTES, 16, bytes per beat; sets the address increment.

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  synchronous reset, active-low
cfg_enable  in  1  run enable; rising edge or level-high in IDLE starts a frame
cfg_loop  in  1  reload and restart automatically after a frame completes (AUTOSTART)
cfg_base_addr  in  39  frame base byte address
cfg_total_words  in  32  beats per frame (for example 1920*1080/4)
fifo_level  in  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
irq_ack  in  1  one-cycle pulse when the host reads the status register
beat_valid  in  1  write beat accepted into the FIFO (wvalid & wready at the refill address)
beat_last  in  1  wlast qualifier for beat_valid
irq_signal  out  1  refill request interrupt, level
status_word  out  128  [127:64]=req_len zero-extended, [63:39]=0, [38:0]=req_addr
words_remaining  out  32  beats still owed in the current frame
frame_done  out  1  one-cycle pulse at frame completion
busy  out  1  high in any state other than IDLE
err_sticky  out  1  protocol error flag; cleared only by reset or a new frame start

Behaviour:
- Reset (s_axi_aresetn low at a clock edge) sets state=IDLE and clears all outputs to 0: irq_signal, status_word, words_remaining, frame_done, busy, err_sticky. Internal beat counter and addresses are also 0.
- States are IDLE, EVAL, IRQ, WAIT_DATA, DONE.
- IDLE:
  - If cfg_enable=1 and cfg_total_words!=0: load rem=cfg_total_words and addr=cfg_base_addr, clear err_sticky, go to EVAL.
  - If cfg_total_words=0: stay in IDLE.
- EVAL, using registered inputs sampled this cycle:
  - cfg_enable=0: go to IDLE (abort).
  - rem=0: go to DONE.
  - Otherwise compute len=min(MAX_BURST, rem) and free=FIFO_DEPTH-fifo_level.
  - If fifo_level<=LOW_WATERMARK and free>=len: latch req_len=len and req_addr=addr, go to IRQ. irq_signal rises on the cycle after the decision (latency 1 from EVAL).
  - Otherwise stay in EVAL.
- IRQ:
  - irq_signal=1; status_word holds stable.
  - irq_ack=1: go to WAIT_DATA; irq_signal=0 from the next cycle.
  - cfg_enable=0 without ack: go to IDLE and drop irq_signal.
  - irq_ack and a disable in the same cycle: the ack wins; the burst is completed.
- WAIT_DATA:
  - Each beat_valid increments cnt.
  - Completion is a beat with cnt==req_len-1. On that beat: rem-=req_len, addr+=req_len*BEAT_BYTES (39-bit wrap), cnt=0. Then go to EVAL if cfg_enable=1, else IDLE.
  - beat_last absent on the final beat: set err_sticky; the burst still completes.
  - beat_last present on an earlier beat: set err_sticky; the burst still completes only on cnt==req_len-1.
  - cfg_enable is ignored while in WAIT_DATA.
- beat_valid in any state other than WAIT_DATA sets err_sticky and changes no other state.
- irq_ack outside IRQ is ignored.
- DONE:
  - frame_done=1 for exactly one cycle.
  - If cfg_loop & cfg_enable: reload rem and addr from cfg and go to EVAL. err_sticky is not cleared on a loop reload.
  - Otherwise go to IDLE.
- words_remaining reflects rem with no delay (registered).
- Arithmetic: len is 9 bits (1..256); free is computed at fifo_level width+1 to avoid underflow; a fifo_level above FIFO_DEPTH is treated as full.
- A reset asserted mid-burst discards the burst; no partial rem update is made.

Decomposition:
- Package image_refill_pkg holds:
  - state enum refill_state_t {IDLE, EVAL, IRQ, WAIT_DATA, DONE};
  - the STATUS_LEN_LSB=64 and STATUS_ADDR_W=39 constants;
  - the function min_len(rem, max).
- No sub-module; a single FSM with a datapath of roughly 200 lines.

Test Plan:
1. Reset for 10 cycles, then release with cfg_enable=0 -> all outputs 0, busy=0, state IDLE.
2. Set cfg_total_words=600, base=0x4_0000_0000, fifo_level=0, enable=1 -> irq with status len=256, addr=0x4_0000_0000. Ack and send 256 beats with last on the 256th. Next irq has len=256, addr=0x4_0000_1000; the third has len=88, addr=0x4_0000_2000. After its 88 beats, frame_done pulses once, words_remaining=0 and the state returns to IDLE.
3. Hold fifo_level=3000 (> LOW_WATERMARK) -> no irq. Drop it to 2048 -> irq appears 1 cycle later.
4. During a 256-beat burst, assert beat_last on beat 100 -> err_sticky=1, the burst still ends after 256 beats, and rem decreases by 256.
5. cfg_loop=1, total=256 -> after frame_done the next irq again shows addr=base and len=256. Pull enable low while in IRQ -> irq_signal drops the next cycle and the state goes to IDLE.
6. Drive beat_valid while in IDLE -> err_sticky=1. Apply reset mid-burst at beat 50 -> all outputs 0; a restart reissues the first request at base.
